// File: rtl/buffer_mux_arbiter.sv
// -----------------------------------------------------------------------------
// buffer_mux_arbiter
//
// Four-requester round-robin arbiter with a one-beat registered output buffer.
// A granted requester's data is captured into out_data and held until the
// downstream side accepts it (out_valid & out_ready). The requester served at
// an acceptance edge is excluded from arbitration at that same edge, so a
// different requester can be loaded back-to-back without an out_valid gap.
//
// Optional feature (define BUFFER_MUX_ARB_LOCK_EN):
//   adds input `lock`. When lock[selector] and req[selector] are both set at
//   an acceptance edge, the same requester is regranted, it is not masked and
//   the round-robin pointer does not advance.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req        in   [3:0] per-requester transfer requests
//   in_data0-3 in   [DATA_WIDTH-1:0] requester data
//   out_ready  in   downstream acceptance
//   lock       in   [3:0] hold-grant request (only with BUFFER_MUX_ARB_LOCK_EN)
//   out_valid  out  out_data holds an unaccepted beat
//   out_data   out  [DATA_WIDTH-1:0] registered mux output
//   selector   out  [1:0] index of current / last granted requester
//   grant      out  [3:0] one-hot of selector while out_valid, else 0
//   ack        out  [3:0] grant qualified by out_valid & out_ready
//   xfer_cnt   out  [15:0] accepted beat count, wraps
// -----------------------------------------------------------------------------
module buffer_mux_arbiter #(
  parameter int DATA_WIDTH = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req,
  input  logic [DATA_WIDTH-1:0] in_data0,
  input  logic [DATA_WIDTH-1:0] in_data1,
  input  logic [DATA_WIDTH-1:0] in_data2,
  input  logic [DATA_WIDTH-1:0] in_data3,
  input  logic                  out_ready,
`ifdef BUFFER_MUX_ARB_LOCK_EN
  input  logic [3:0]            lock,
`endif
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            selector,
  output logic [3:0]            grant,
  output logic [3:0]            ack,
  output logic [15:0]           xfer_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            sel_q, sel_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [15:0]           cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] in_data [4];
  assign in_data[0] = in_data0;
  assign in_data[1] = in_data1;
  assign in_data[2] = in_data2;
  assign in_data[3] = in_data3;

  logic accept;
  assign accept = (state_q == BUSY) && out_ready;

  // Lock only matters while the locked requester is still asking.
  logic lock_hold;
`ifdef BUFFER_MUX_ARB_LOCK_EN
  assign lock_hold = lock[sel_q] & req[sel_q];
`else
  assign lock_hold = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Round-robin pick. At an acceptance edge the search starts just past the
  // requester being served (the pointer value it is about to take) and that
  // requester is masked out for this one edge only.
  // ---------------------------------------------------------------------------
  logic [3:0] eligible;
  logic [1:0] start;
  logic       found;
  logic [1:0] win;

  // NOTE: every signal driven in always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    eligible = req;
    start    = ptr_q;
    found    = 1'b0;
    win      = 2'd0;
    if (accept) begin
      start              = sel_q + 2'd1;
      eligible[sel_q]    = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      if (!found && eligible[start + 2'(k)]) begin
        found = 1'b1;
        win   = start + 2'(k);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // out_ready is irrelevant here; nothing moves without a request.
        if (found) begin
          state_d = BUSY;
          data_d  = in_data[win];
          sel_d   = win;
        end
      end
      BUSY: begin
        if (out_ready) begin
          cnt_d = cnt_q + 16'd1;
          if (lock_hold) begin
            data_d = in_data[sel_q];
          end else begin
            ptr_d = sel_q + 2'd1;
            if (found) begin
              data_d = in_data[win];
              sel_d  = win;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge. Every register,
  // including the data buffer, is reset so a discarded beat never leaks out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid = (state_q == BUSY);
  assign out_data  = data_q;
  assign selector  = sel_q;
  assign grant     = out_valid ? (4'b0001 << sel_q) : 4'b0000;
  assign ack       = grant & {4{out_valid & out_ready}};
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_buffer_mux_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for buffer_mux_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_buffer_mux_arbiter;

  localparam int DW = 40;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req;
  logic [DW-1:0] in_data0, in_data1, in_data2, in_data3;
  logic          out_ready;
  logic [3:0]    lock;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    selector;
  logic [3:0]    grant;
  logic [3:0]    ack;
  logic [15:0]   xfer_cnt;

  buffer_mux_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .out_ready (out_ready),
`ifdef BUFFER_MUX_ARB_LOCK_EN
    .lock      (lock),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .selector  (selector),
    .grant     (grant),
    .ack       (ack),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one held beat, a rotating priority start, a beat count.
  // ---------------------------------------------------------------------------
  bit          m_valid;
  int          m_sel;
  logic [DW-1:0] m_data;
  int          m_ptr;
  int          m_cnt;

  function automatic logic [DW-1:0] data_of(input int i);
    case (i)
      0: return in_data0;
      1: return in_data1;
      2: return in_data2;
      default: return in_data3;
    endcase
  endfunction

  // First requesting index found walking upward from `from`, skipping `skip`.
  function automatic int pick(input int from, input int skip);
    for (int off = 0; off < 4; off++) begin
      int r = (from + off) % 4;
      if (req[r] && r != skip) return r;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_sel = 0; m_data = '0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    int w;
    if (m_valid && out_ready) begin
      m_cnt = (m_cnt + 1) % 65536;
      if (lock[m_sel] && req[m_sel]) begin
        m_data = data_of(m_sel);
      end else begin
        m_ptr = (m_sel + 1) % 4;
        w = pick(m_ptr, m_sel);
        if (w >= 0) begin m_sel = w; m_data = data_of(w); end
        else m_valid = 0;
      end
    end else if (!m_valid) begin
      w = pick(m_ptr, -1);
      if (w >= 0) begin m_sel = w; m_data = data_of(w); m_valid = 1; end
    end
  endtask

  function automatic logic [3:0] exp_grant();
    return m_valid ? (4'b0001 << m_sel) : 4'b0000;
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, out_valid, m_valid);
    check({tag, ".data"},  out_data,  m_data);
    check({tag, ".sel"},   selector,  m_sel[1:0]);
    check({tag, ".grant"}, grant,     exp_grant());
    check({tag, ".cnt"},   xfer_cnt,  m_cnt[15:0]);
  endtask

  // Called with inputs already driven after a falling edge; returns at the
  // next falling edge.
  task automatic tick(input string tag);
    #1;
    check({tag, ".ack"}, ack, (m_valid && out_ready) ? exp_grant() : 4'b0000);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] r, input logic rdy);
    req = r; out_ready = rdy;
  endtask

  task automatic set_data(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    in_data0 = d0; in_data1 = d1; in_data2 = d2; in_data3 = d3;
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    check({tag, ".ack"}, ack, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    req = '0; out_ready = 1'b0; lock = '0;
    set_data('0, '0, '0, '0);
    model_reset();
    @(negedge clk);
    apply_reset("rst");

    // Single beat accepted immediately; ack and count follow one cycle later.
    set_data(40'hABA, 40'h0, 40'h0, 40'h0);
    drive(4'b0001, 1'b1);
    tick("single");
    check("single.data_lit", out_data, 40'hABA);
    drive(4'b0000, 1'b1);
    tick("single_acc");
    check("single.cnt_lit", xfer_cnt, 16'd1);

    // All four requesting: back-to-back 1,2,3,4 then wrap to 1.
    apply_reset("rst2");
    set_data(40'd1, 40'd2, 40'd3, 40'd4);
    drive(4'b1111, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick("rr4");
      check("rr4.data_lit", out_data, 40'(i % 4 + 1));
    end

    // Held beat while downstream stalls and the source data moves.
    apply_reset("rst3");
    set_data(40'd0, 40'd2, 40'd0, 40'd0);
    drive(4'b0010, 1'b0);
    tick("stall_load");
    in_data1 = 40'd7;
    for (int i = 0; i < 5; i++) begin
      drive((i % 2) ? 4'b1111 : 4'b0000, 1'b0);
      tick("stall");
      check("stall.data_lit", out_data, 40'd2);
      check("stall.grant_lit", grant, 4'b0010);
    end
    drive(4'b0000, 1'b1);
    tick("stall_release");

    // Lone requester: mask cycle between beats gives a 1,0,1,0 valid pattern.
    apply_reset("rst4");
    drive(4'b0100, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick("lone");
      check("lone.valid_lit", out_valid, (i % 2 == 0));
    end

    // Reset in the middle of a held beat.
    apply_reset("rst5");
    drive(4'b0001, 1'b0);
    tick("mid_load");
    #2;
    apply_reset("mid_rst");
    check("mid_rst.cnt_lit", xfer_cnt, 16'd0);

`ifdef BUFFER_MUX_ARB_LOCK_EN
    // Locked requester 0 keeps the grant until the lock drops.
    set_data(40'h10, 40'h11, 40'h0, 40'h0);
    drive(4'b0011, 1'b1);
    lock = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick("lock");
      check("lock.sel_lit", selector, 2'd0);
    end
    lock = 4'b0000;
    tick("unlock");
    check("unlock.sel_lit", selector, 2'd1);
    apply_reset("rst6");
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      req       = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      set_data({8'($urandom), 32'($urandom)}, {8'($urandom), 32'($urandom)},
               {8'($urandom), 32'($urandom)}, {8'($urandom), 32'($urandom)});
`ifdef BUFFER_MUX_ARB_LOCK_EN
      lock = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
`endif
      tick("rand");
      if (i == 200) apply_reset("rand_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
